// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Drives an N_LEDS-wide LED bank with a selectable animation
//            (rotate left, rotate right, bounce, blink). A prescaler with
//            2**NB_SEL selectable limits sets the step rate. A manual
//            single-step input advances the pattern while the prescaler is
//            paused. A one-cycle step pulse is exported for ILA triggering.
// Ports    : clock    - system clock, rising edge
//            i_reset  - synchronous active-high reset
//            i_enable - 1 = prescaler runs, 0 = hold counter and pattern
//            i_sel    - limit select k, limit = 2**(LIM_BASE+k) - 1
//            i_mode   - 0 rotate-left, 1 rotate-right, 2 bounce, 3 blink
//            i_step   - manual step, honoured only while i_enable = 0
//            i_color  - RGB colour select, 0 = blue, 1 = green
//            o_led    - current pattern (registered)
//            o_led_b  - pattern when i_color = 0, else zeros
//            o_led_g  - pattern when i_color = 1, else zeros
//            o_tick   - one-cycle pulse when a new pattern first shows
//            o_dir    - bounce direction, 0 = toward MSB, 1 = toward LSB
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int N_LEDS   = 8,
    parameter int NB_COUNT = 32,
    parameter int NB_SEL   = 2,
    parameter int LIM_BASE = 22
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_SEL-1:0] i_sel,
    input  logic [1:0]        i_mode,
    input  logic              i_step,
    input  logic              i_color,
    output logic [N_LEDS-1:0] o_led,
    output logic [N_LEDS-1:0] o_led_b,
    output logic [N_LEDS-1:0] o_led_g,
    output logic              o_tick,
    output logic              o_dir
);

    localparam logic [NB_COUNT-1:0] C_CNT_ONE = NB_COUNT'(1);
    localparam logic [N_LEDS-1:0]   C_LED_LSB = N_LEDS'(1);
    localparam logic [1:0]          C_MODE_ROL    = 2'd0;
    localparam logic [1:0]          C_MODE_ROR    = 2'd1;
    localparam logic [1:0]          C_MODE_BOUNCE = 2'd2;

    logic [NB_COUNT-1:0] r_count;
    logic [N_LEDS-1:0]   r_pattern;
    logic                r_dir;
    logic [1:0]          r_mode;
    logic                r_tick;

    logic [NB_COUNT-1:0] w_limit;
    logic                w_at_limit;
    logic                w_do_step;
    logic [N_LEDS-1:0]   w_init;
    logic [N_LEDS-1:0]   w_next_pattern;
    logic                w_next_dir;

    // Limit is an all-ones value of width LIM_BASE+k.
    assign w_limit    = (C_CNT_ONE << (LIM_BASE + int'(i_sel))) - C_CNT_ONE;
    // >= rather than == so that lowering i_sel below the running count
    // steps immediately instead of wrapping the whole counter range.
    assign w_at_limit = (r_count >= w_limit);
    assign w_do_step  = i_enable ? w_at_limit : i_step;

    // Blink starts dark; every other mode starts with a single lit LSB.
    assign w_init = (i_mode == 2'd3) ? '0 : C_LED_LSB;

    always_comb begin
        w_next_pattern = r_pattern;
        w_next_dir     = r_dir;
        case (r_mode)
            C_MODE_ROL: w_next_pattern = {r_pattern[N_LEDS-2:0], r_pattern[N_LEDS-1]};
            C_MODE_ROR: w_next_pattern = {r_pattern[0], r_pattern[N_LEDS-1:1]};
            C_MODE_BOUNCE: begin
                // Reverse on reaching an end; the reversal step itself
                // already moves one position back, so the ends are not
                // repeated and the period is 2*(N_LEDS-1).
                if (!r_dir) begin
                    if (r_pattern[N_LEDS-1]) begin
                        w_next_dir     = 1'b1;
                        w_next_pattern = r_pattern >> 1;
                    end else begin
                        w_next_pattern = r_pattern << 1;
                    end
                end else begin
                    if (r_pattern[0]) begin
                        w_next_dir     = 1'b0;
                        w_next_pattern = r_pattern << 1;
                    end else begin
                        w_next_pattern = r_pattern >> 1;
                    end
                end
            end
            default: w_next_pattern = ~r_pattern;
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset || (i_mode != r_mode)) begin
            // Reset and mode change restart the animation identically.
            r_count   <= '0;
            r_mode    <= i_mode;
            r_pattern <= w_init;
            r_dir     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_do_step;
            if (i_enable) begin
                r_count <= w_at_limit ? '0 : (r_count + C_CNT_ONE);
            end
            if (w_do_step) begin
                r_pattern <= w_next_pattern;
                r_dir     <= w_next_dir;
            end
        end
    end

    assign o_led   = r_pattern;
    assign o_tick  = r_tick;
    assign o_dir   = r_dir;
    assign o_led_b = i_color ? '0 : r_pattern;
    assign o_led_g = i_color ? r_pattern : '0;

endmodule
`default_nettype wire
